// File: rtl/avalon_pio_ext_pkg.sv
// avalon_pio_ext_pkg: register addresses, address type and counter-width helper for avalon_pio_ext
package avalon_pio_ext_pkg;
  typedef logic [2:0] pio_addr_t;
  localparam pio_addr_t ADDR_DATA_IN  = 3'd0;
  localparam pio_addr_t ADDR_DATA_OUT = 3'd1;
  localparam pio_addr_t ADDR_OUT_SET  = 3'd2;
  localparam pio_addr_t ADDR_OUT_CLR  = 3'd3;
  localparam pio_addr_t ADDR_IRQ_MASK = 3'd4;
  localparam pio_addr_t ADDR_EDGE_CAP = 3'd5;
  localparam pio_addr_t ADDR_EDGE_POL = 3'd6;
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/avalon_pio_ext_debounce.sv
// pio_debounce_ch: one input channel (clk, reset, raw in; deb level, rise/fall strobes coincident with deb update)
module pio_debounce_ch
  import avalon_pio_ext_pkg::*;
#(
  parameter int   DEB_CYCLES = 50000,
  parameter logic RESET_VAL  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic deb,
  output logic rise,
  output logic fall
);
  localparam int CW = clog2_min1(DEB_CYCLES + 1);
  logic          sync0, sync1, upd;
  logic [CW-1:0] cnt;
  always_comb begin
    upd  = (sync1 != deb) && ((DEB_CYCLES == 0) || (cnt == CW'(DEB_CYCLES - 1)));
    rise = upd & sync1;
    fall = upd & ~sync1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0 <= RESET_VAL;
      sync1 <= RESET_VAL;
      deb   <= RESET_VAL;
      cnt   <= '0;
    end else begin
      sync0 <= raw;
      sync1 <= sync0;
      deb   <= upd ? sync1 : deb;
      cnt   <= (sync1 == deb || upd) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/avalon_pio_ext.sv
// avalon_pio_ext: Avalon-MM PIO (address/read/write/writedata/readdata) with debounced edge-capturing pio_in, set/clear pio_out and level irq
module avalon_pio_ext
  import avalon_pio_ext_pkg::*;
#(
  parameter int                   IN_WIDTH      = 2,
  parameter int                   OUT_WIDTH     = 8,
  parameter int                   DEB_CYCLES    = 50000,
  parameter logic [IN_WIDTH-1:0]  IN_RESET_VAL  = '1,
  parameter logic [OUT_WIDTH-1:0] OUT_RESET_VAL = '0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  pio_addr_t            address,
  input  logic                 read,
  input  logic                 write,
  input  logic [31:0]          writedata,
  output logic [31:0]          readdata,
  input  logic [IN_WIDTH-1:0]  pio_in,
  output logic [OUT_WIDTH-1:0] pio_out,
  output logic                 irq
);
  logic [IN_WIDTH-1:0]  deb, rise, fall, edge_ev, edge_cap, edge_cap_next, mask, mask_next, edge_pol, pol_next;
  logic [IN_WIDTH-1:0]  wd_in;
  logic [OUT_WIDTH-1:0] wd_out, out_next;
  logic [31:0]          rd_mux;
  logic                 unused_wd;
  assign unused_wd = ^writedata;
  for (genvar i = 0; i < IN_WIDTH; i++) begin : g_ch
    pio_debounce_ch #(
      .DEB_CYCLES(DEB_CYCLES),
      .RESET_VAL (IN_RESET_VAL[i])
    ) u_ch (
      .clk  (clk),
      .reset(reset),
      .raw  (pio_in[i]),
      .deb  (deb[i]),
      .rise (rise[i]),
      .fall (fall[i])
    );
  end
  always_comb begin
    wd_in         = writedata[IN_WIDTH-1:0];
    wd_out        = writedata[OUT_WIDTH-1:0];
    edge_ev       = (rise & edge_pol) | (fall & ~edge_pol);
    // a fresh edge overrides a same-cycle write-1-to-clear
    edge_cap_next = ((write && address == ADDR_EDGE_CAP) ? edge_cap & ~wd_in : edge_cap) | edge_ev;
    mask_next     = (write && address == ADDR_IRQ_MASK) ? wd_in : mask;
    pol_next      = (write && address == ADDR_EDGE_POL) ? wd_in : edge_pol;
    out_next      = !write                    ? pio_out :
                    address == ADDR_DATA_OUT  ? wd_out :
                    address == ADDR_OUT_SET   ? pio_out | wd_out :
                    address == ADDR_OUT_CLR   ? pio_out & ~wd_out : pio_out;
    rd_mux        = '0;
    case (address)
      ADDR_DATA_IN:  rd_mux = 32'(deb);
      ADDR_DATA_OUT: rd_mux = 32'(pio_out);
      ADDR_IRQ_MASK: rd_mux = 32'(mask);
      ADDR_EDGE_CAP: rd_mux = 32'(edge_cap);
      ADDR_EDGE_POL: rd_mux = 32'(edge_pol);
      default:       rd_mux = '0;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      readdata <= '0;
      pio_out  <= OUT_RESET_VAL;
      irq      <= 1'b0;
      mask     <= '0;
      edge_cap <= '0;
      edge_pol <= '1;
    end else begin
      readdata <= read ? rd_mux : '0;
      pio_out  <= out_next;
      irq      <= |(edge_cap_next & mask_next);
      mask     <= mask_next;
      edge_cap <= edge_cap_next;
      edge_pol <= pol_next;
    end
  end
endmodule

// File: tb/tb_avalon_pio_ext.sv
// tb_avalon_pio_ext: table-driven and scoreboarded checks of avalon_pio_ext
module tb_avalon_pio_ext;
  localparam int DEB = 4;
  logic        clk = 0, reset = 1, read = 0, write = 0;
  logic [2:0]  address = '0;
  logic [31:0] writedata = '0, readdata;
  logic [1:0]  pio_in = 2'b11, din_exp = 2'b11;
  logic [7:0]  pio_out;
  logic        irq;
  int          passed = 0, total = 0;
  typedef struct {string name; logic [31:0] exp;} sb_t;
  typedef struct {logic [2:0] addr; logic [31:0] wd; logic [7:0] exp_out;} vec_t;
  sb_t  sb[$];
  vec_t vecs[7];
  avalon_pio_ext #(.IN_WIDTH(2), .OUT_WIDTH(8), .DEB_CYCLES(DEB)) dut (
    .clk(clk), .reset(reset), .address(address), .read(read), .write(write),
    .writedata(writedata), .readdata(readdata), .pio_in(pio_in), .pio_out(pio_out), .irq(irq)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic expect_rd(input string name, input logic [31:0] exp);
    sb_t e;
    e.name = name;
    e.exp  = exp;
    sb.push_back(e);
  endtask
  task automatic check_sb;
    sb_t e;
    if (sb.size() == 0) begin
      total++;
      $display("FAIL scoreboard: readdata 0x%0h with no expected entry", readdata);
    end else begin
      e = sb.pop_front();
      chk(e.name, readdata, e.exp);
    end
  endtask
  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    address = a; writedata = d; write = 1;
    tick();
    write = 0;
  endtask
  task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
    address = a; read = 1;
    expect_rd(name, exp);
    tick();
    read = 0;
    check_sb();
  endtask
  // hold pio_in[b]=v for n cycles while reading DATA_IN every cycle; an accepted change
  // updates the debounced bit DEB+2 edges after the drive (2 sync stages + DEB), irq follows
  // at that edge and the read pipeline shows it one edge later
  task automatic drive(input int b, input logic v, input int n, input bit change,
                       input logic irq_before, input logic irq_after);
    logic [1:0] nd;
    nd = din_exp;
    if (change) nd[b] = v;
    pio_in[b] = v; address = 3'd0; read = 1;
    for (int k = 1; k <= n; k++) begin
      expect_rd("data_in", (k >= DEB + 3) ? 32'(nd) : 32'(din_exp));
      tick();
      check_sb();
      chk("irq_track", 32'(irq), 32'((k >= DEB + 2) ? irq_after : irq_before));
    end
    read = 0;
    din_exp = nd;
  endtask
  initial begin
    vecs[0] = '{3'd1, 32'h0F,  8'h0F};
    vecs[1] = '{3'd2, 32'h30,  8'h3F};
    vecs[2] = '{3'd3, 32'h05,  8'h3A};
    vecs[3] = '{3'd1, 32'h1FF, 8'hFF};
    vecs[4] = '{3'd3, 32'hF0,  8'h0F};
    vecs[5] = '{3'd2, 32'hA0,  8'hAF};
    vecs[6] = '{3'd1, 32'h3A,  8'h3A};
    reset = 1;
    tick(); tick();
    chk("rst_pio_out", 32'(pio_out), 32'h00);
    chk("rst_irq", 32'(irq), 32'h0);
    chk("rst_readdata", readdata, 32'h0);
    reset = 0;
    rd(3'd0, 32'h3, "rst_data_in");
    rd(3'd4, 32'h0, "rst_mask");
    rd(3'd5, 32'h0, "rst_edge_cap");
    rd(3'd6, 32'h3, "rst_edge_pol");
    rd(3'd7, 32'h0, "reserved");
    rd(3'd1, 32'h0, "rst_data_out");
    for (int i = 0; i < 7; i++) begin
      wr(vecs[i].addr, vecs[i].wd);
      chk($sformatf("pio_out_vec%0d", i), 32'(pio_out), 32'(vecs[i].exp_out));
    end
    rd(3'd1, 32'h3A, "data_out_rd");
    rd(3'd2, 32'h0, "out_set_rd");
    rd(3'd3, 32'h0, "out_clr_rd");
    tick();
    chk("idle_readdata", readdata, 32'h0);
    address = 3'd1; writedata = 32'h55; write = 1; read = 1;
    expect_rd("rw_same_cycle", 32'h3A);
    tick();
    write = 0; read = 0;
    check_sb();
    chk("rw_pio_out", 32'(pio_out), 32'h55);
    rd(3'd1, 32'h55, "rw_readback");
    drive(0, 1'b0, 3, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b1, 6, 1'b0, 1'b0, 1'b0);
    drive(0, 1'b0, 10, 1'b1, 1'b0, 1'b0);
    rd(3'd5, 32'h0, "fall_pol1_no_cap");
    drive(0, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    rd(3'd5, 32'h1, "rise_pol1_cap");
    wr(3'd5, 32'h1);
    rd(3'd5, 32'h0, "w1c_clear");
    wr(3'd6, 32'h0);
    wr(3'd4, 32'h1);
    chk("unmask_no_cap_irq", 32'(irq), 32'h0);
    drive(0, 1'b0, 10, 1'b1, 1'b0, 1'b1);
    rd(3'd5, 32'h1, "fall_pol0_cap");
    drive(0, 1'b1, 10, 1'b1, 1'b1, 1'b1);
    wr(3'd5, 32'h1);
    chk("w1c_irq_drop", 32'(irq), 32'h0);
    rd(3'd5, 32'h0, "w1c_after_irq");
    drive(1, 1'b0, 10, 1'b1, 1'b0, 1'b0);
    drive(1, 1'b1, 10, 1'b1, 1'b0, 1'b0);
    wr(3'd4, 32'h3);
    chk("unmask_irq_rise", 32'(irq), 32'h1);
    wr(3'd4, 32'h1);
    chk("mask_irq_fall", 32'(irq), 32'h0);
    rd(3'd4, 32'h1, "mask_rd");
    drive(0, 1'b0, 10, 1'b1, 1'b0, 1'b1);
    wr(3'd6, 32'h2);
    rd(3'd5, 32'h3, "pol_change_keeps_cap");
    rd(3'd6, 32'h2, "edge_pol_rd");
    wr(3'd6, 32'h0);
    chk("pol_change_irq", 32'(irq), 32'h1);
    drive(0, 1'b1, 10, 1'b1, 1'b1, 1'b1);
    pio_in[0] = 1'b0;
    repeat (DEB + 1) tick();
    chk("no_read_readdata", readdata, 32'h0);
    wr(3'd5, 32'h3);
    chk("w1c_vs_edge_irq", 32'(irq), 32'h1);
    din_exp[0] = 1'b0;
    rd(3'd5, 32'h1, "w1c_vs_edge_cap");
    rd(3'd0, 32'h2, "w1c_vs_edge_din");
    pio_in[0] = 1'b1;
    repeat (3) tick();
    wr(3'd1, 32'hAA);
    chk("pre_reset_out", 32'(pio_out), 32'hAA);
    reset = 1; read = 1; address = 3'd5;
    tick();
    reset = 0; read = 0;
    chk("midrst_pio_out", 32'(pio_out), 32'h00);
    chk("midrst_irq", 32'(irq), 32'h0);
    chk("midrst_readdata", readdata, 32'h0);
    din_exp = 2'b11;
    drive(0, 1'b1, 8, 1'b0, 1'b0, 1'b0);
    rd(3'd5, 32'h0, "midrst_edge_cap");
    rd(3'd4, 32'h0, "midrst_mask");
    rd(3'd6, 32'h3, "midrst_edge_pol");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
